// File: rtl/tca_pkg.sv
// Shared definitions for the toggle-cell arbiter.
// Provides the 2-bit FSM state encoding used by toggle_cell_arbiter.
package tca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/toggle_cell_arbiter_if.sv
// Requester-side bus of the toggle-cell arbiter.
// Signals:
//   req      NREQ        request per requester
//   data     NREQ*WIDTH  word i at data[i*WIDTH +: WIDTH]
//   gnt      NREQ        one-hot grant, held for the whole transaction
//   busy     1           arbiter not idle
//   done     1           one-cycle result-valid pulse
//   done_id  IDXW        requester that completed
//   parity   1           XOR of the granted word
// Modports: master = requester logic, slave = arbiter.
interface toggle_cell_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned IDXW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDXW-1:0]       done_id;
  logic                  parity;

  modport master (
    output req, data,
    input  gnt, busy, done, done_id, parity
  );

  modport slave (
    input  req, data,
    output gnt, busy, done, done_id, parity
  );

endinterface

// File: rtl/simple_module.sv
// Shared toggle cell: q clears while en=0, toggles by d while en=1.
// Deliberately has no reset; its owner clears it by holding en low.
// Ports:
//   clk  in   clock, rising edge
//   en   in   1: q <= q ^ d, 0: q <= 0
//   d    in   toggle input
//   q    out  cell state
module simple_module (
  input  logic clk,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (en) q <= q ^ d;
    else    q <= 1'b0;
  end

endmodule

// File: rtl/toggle_cell_arbiter.sv
// Round-robin arbiter sharing one toggle cell among NREQ requesters to
// compute the XOR reduction of the granted WIDTH-bit word, LSB first.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of toggle_cell_arbiter_if (req/data in,
//          gnt/busy/done/done_id/parity out)
module toggle_cell_arbiter
  import tca_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  toggle_cell_arbiter_if.slave bus
);

  localparam int unsigned IDXW = $clog2(NREQ);
  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  state_t           state;
  logic [NREQ-1:0]  gnt_r;
  logic             busy_r;
  logic [IDXW-1:0]  last;
  logic [IDXW-1:0]  done_id_r;
  logic [WIDTH-1:0] shreg;
  logic [CNTW-1:0]  cnt;
  logic             parity_r;

  logic [WIDTH-1:0] words [NREQ];
  logic [IDXW:0]    pick;
  logic             pick_vld;
  logic [IDXW-1:0]  pick_idx;
  logic             done_c;
  logic             cell_en;
  logic             cell_d;
  logic             cell_q;

  // First requester at or after ptr+1 (mod NREQ); returns {valid, index}.
  // Walking the offsets downward lets the nearest one overwrite the result.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IDXW-1:0] ptr);
    logic [IDXW:0]   res;
    logic [IDXW-1:0] idx;
    int unsigned     j;
    res = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      j   = (32'(ptr) + k) % NREQ;
      idx = IDXW'(j);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Unpack the flat data bus into per-requester words.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      words[i] = bus.data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    pick = rr_pick(bus.req, last);
  end

  assign pick_vld = pick[IDXW];
  assign pick_idx = pick[IDXW-1:0];

  // Arbitration FSM with its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt_r     <= '0;
      busy_r    <= 1'b0;
      last      <= IDXW'(NREQ - 1);
      done_id_r <= '0;
      shreg     <= '0;
      cnt       <= '0;
      parity_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_r     <= NREQ'(1) << pick_idx;
            shreg     <= words[pick_idx];
            last      <= pick_idx;
            done_id_r <= pick_idx;
            busy_r    <= 1'b1;
            state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shreg <= shreg >> 1;
          // Counter stops at WIDTH-1 instead of wrapping past it.
          if (cnt == CNTW'(WIDTH - 1)) state <= ST_REPORT;
          else                         cnt   <= cnt + CNTW'(1);
        end
        ST_REPORT: begin
          parity_r <= cell_q;
          gnt_r    <= '0;
          busy_r   <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Cell is cleared in every state except SHIFT.
  always_comb begin
    cell_en = (state == ST_SHIFT);
    cell_d  = shreg[0];
  end

  simple_module u_cell (
    .clk (clk),
    .en  (cell_en),
    .d   (cell_d),
    .q   (cell_q)
  );

  assign done_c      = (state == ST_REPORT);
  assign bus.gnt     = gnt_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_c;
  assign bus.done_id = done_id_r;
  // The result is visible straight from the cell during the done cycle.
  assign bus.parity  = done_c ? cell_q : parity_r;

endmodule

// File: tb/tb_toggle_cell_arbiter.sv
// Self-checking bench for toggle_cell_arbiter (NREQ=4, WIDTH=8).
module tb_toggle_cell_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  toggle_cell_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  toggle_cell_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vecs        = 0;
  int miscompares = 0;
  int last_m;

  typedef struct {
    logic [3:0] req;
    logic [7:0] word;
    int         exp_id;
    int         exp_par;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: nearest requester after the last winner, wrapping mod NREQ.
  function automatic int model_pick(input logic [3:0] r);
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (r[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int word_par(input logic [31:0] d, input int i);
    logic [7:0] w;
    w = d[i*8 +: 8];
    return $countones(w) % 2;
  endfunction

  // Drive a request, wait (bounded) for grant and done, report observations.
  task automatic do_txn(input logic [3:0] r, input logic [31:0] d,
                        input bit mod_en, input logic [3:0] mod_r, input logic [31:0] mod_d,
                        output bit got, output int lat, output int total,
                        output logic [3:0] g, output logic b,
                        output logic [1:0] id, output logic par);
    int n_g;
    bit seen;
    got = 0; lat = 0; total = 0; g = '0; b = 1'b0; id = '0; par = 1'b0;
    seen = 0; n_g = 0;
    bus.req  = r;
    bus.data = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!seen && bus.gnt != '0) begin
        seen = 1;
        g    = bus.gnt;
        b    = bus.busy;
        n_g  = n;
        if (mod_en) begin
          bus.req  = mod_r;
          bus.data = mod_d;
        end
      end
      if (bus.done) begin
        got   = 1;
        total = n;
        lat   = n - n_g;
        id    = bus.done_id;
        par   = bus.parity;
        break;
      end
    end
  endtask

  // One checked transaction; negative expectations come from the model.
  task automatic txn(input string name, input logic [3:0] r, input logic [31:0] d,
                     input bit mod_en, input logic [3:0] mod_r, input logic [31:0] mod_d,
                     input int exp_id, input int exp_par, input bit chk_space);
    int         e_id;
    int         e_par;
    bit         got;
    int         lat;
    int         total;
    logic [3:0] g;
    logic       b;
    logic [1:0] id;
    logic       par;
    e_id  = (exp_id >= 0) ? exp_id : model_pick(r);
    e_par = (exp_par >= 0) ? exp_par : word_par(d, e_id);
    do_txn(r, d, mod_en, mod_r, mod_d, got, lat, total, g, b, id, par);
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({name, "_gnt"}, 32'(g), 32'(1) << e_id);
      chk({name, "_busy"}, 32'(b), 32'd1);
      chk({name, "_latency"}, 32'(lat), 32'(WIDTH + 1));
      chk({name, "_done_id"}, 32'(id), 32'(e_id));
      chk({name, "_parity"}, 32'(par), 32'(e_par));
      if (chk_space) chk({name, "_spacing"}, 32'(total), 32'(WIDTH + 3));
    end
    last_m = e_id;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] d2;
    bit          seen;
    int          ndone;
    int          gap;

    tbl[0] = '{4'b0001, 8'hA5, 0, 0};
    tbl[1] = '{4'b0010, 8'h07, 1, 1};
    tbl[2] = '{4'b0010, 8'h00, 1, 0};
    tbl[3] = '{4'b0010, 8'hFF, 1, 0};
    tbl[4] = '{4'b0010, 8'h80, 1, 1};
    tbl[5] = '{4'b0100, 8'h01, 2, 1};
    tbl[6] = '{4'b1000, 8'hFE, 3, 1};
    tbl[7] = '{4'b0001, 8'h3C, 0, 0};

    bus.req  = '0;
    bus.data = '0;
    last_m   = NREQ - 1;
    repeat (2) @(negedge clk);
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_done_id", 32'(bus.done_id), 32'd0);
    chk("reset_parity", 32'(bus.parity), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-requester words from the table; result must hold after done.
    for (int i = 0; i < 8; i++) begin
      d = $urandom();
      d[tbl[i].exp_id*8 +: 8] = tbl[i].word;
      txn($sformatf("tbl%0d", i), tbl[i].req, d, 1'b0, '0, '0,
          tbl[i].exp_id, tbl[i].exp_par, 1'b0);
      bus.req = '0;
      @(negedge clk);
      chk($sformatf("tbl%0d_parity_hold", i), 32'(bus.parity), 32'(tbl[i].exp_par));
      chk($sformatf("tbl%0d_done_low", i), 32'(bus.done), 32'd0);
      chk($sformatf("tbl%0d_busy_low", i), 32'(bus.busy), 32'd0);
    end

    // All four requesting from reset: served 0,1,2,3, then 0 again.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = NREQ - 1;
    d = $urandom();
    txn("rr0", 4'b1111, d, 1'b0, '0, '0, 0, -1, 1'b0);
    txn("rr1", 4'b1110, d, 1'b0, '0, '0, 1, -1, 1'b1);
    txn("rr2", 4'b1100, d, 1'b0, '0, '0, 2, -1, 1'b1);
    txn("rr3", 4'b1000, d, 1'b0, '0, '0, 3, -1, 1'b1);
    txn("rr4", 4'b1111, d, 1'b0, '0, '0, 0, -1, 1'b1);
    bus.req = '0;
    @(negedge clk);

    // Data and req changes after the grant edge are ignored.
    d  = 32'h0001_0000;
    d2 = 32'h0003_0000;
    txn("late_change", 4'b0100, d, 1'b1, 4'b0000, d2, 2, 1, 1'b0);
    @(negedge clk);

    // With last=1, requester 3 wins over 1; back-to-back spacing.
    d = $urandom();
    txn("pre_last1", 4'b0010, d, 1'b0, '0, '0, 1, -1, 1'b0);
    txn("rr_3_first", 4'b1010, d, 1'b0, '0, '0, 3, -1, 1'b1);
    txn("rr_1_next", 4'b0010, d, 1'b0, '0, '0, 1, -1, 1'b1);
    bus.req = '0;
    @(negedge clk);

    // Reset in the middle of SHIFT aborts with no done.
    bus.req  = 4'b0001;
    bus.data = 32'h0000_0001;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        seen = 1;
        break;
      end
    end
    chk("abort_gnt_seen", 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    chk("abort_gnt", 32'(bus.gnt), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = NREQ - 1;
    ndone  = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    txn("after_abort", 4'b0001, 32'h0000_0001, 1'b0, '0, '0, 0, 1, 1'b0);
    bus.req = '0;
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      gap = (i == 0) ? 1 : $urandom_range(0, 2);
      if (gap > 0) begin
        bus.req = '0;
        repeat (gap) @(negedge clk);
      end
      d  = $urandom();
      d2 = $urandom();
      txn($sformatf("rand%0d", i), 4'($urandom_range(1, 15)), d,
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d2,
          -1, -1, (gap == 0));
    end
    bus.req = '0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
